// File: rtl/clk_disp_pkg.sv
// Shared types and helpers for the clock display scan block: conversion FSM
// states, digit count, 7-segment encoding and digit-index to anode mapping.
package clk_disp_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        CONV = 1'b1
    } conv_state_t;

    localparam int NUM_DIGITS = 6;

    // Active-high gfedcba pattern for one BCD digit; codes above 9 stay blank.
    function automatic logic [6:0] seg_encode(input logic [3:0] digit);
        logic [6:0] code;
        case (digit)
            4'd0:    code = 7'h3F;
            4'd1:    code = 7'h06;
            4'd2:    code = 7'h5B;
            4'd3:    code = 7'h4F;
            4'd4:    code = 7'h66;
            4'd5:    code = 7'h6D;
            4'd6:    code = 7'h7D;
            4'd7:    code = 7'h07;
            4'd8:    code = 7'h7F;
            4'd9:    code = 7'h6F;
            default: code = 7'h00;
        endcase
        return code;
    endfunction

    // Digit index 0 is the leftmost position, which is anode bit 5.
    function automatic logic [NUM_DIGITS-1:0] digit_anode(input logic [2:0] idx);
        logic [NUM_DIGITS-1:0] onehot;
        case (idx)
            3'd0:    onehot = 6'b100000;
            3'd1:    onehot = 6'b010000;
            3'd2:    onehot = 6'b001000;
            3'd3:    onehot = 6'b000100;
            3'd4:    onehot = 6'b000010;
            3'd5:    onehot = 6'b000001;
            default: onehot = 6'b000000;
        endcase
        return onehot;
    endfunction

endpackage

// File: rtl/clk_bcd_conv.sv
// Single 6-bit binary to two-digit BCD converter. A start pulse loads the
// value; afterwards one ten is removed per cycle until the remainder drops
// below ten, at which point done is high and tens/units hold the result.
module clk_bcd_conv
    import clk_disp_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [5:0] value,
    output logic [3:0] tens,
    output logic [3:0] units,
    output logic       done
);

    logic [5:0] rem;

    // Load on start, otherwise peel off one ten per cycle while rem is 10 or more.
    always_ff @(posedge clk) begin
        if (rst) begin
            rem  <= '0;
            tens <= '0;
        end else if (start) begin
            rem  <= value;
            tens <= '0;
        end else if (rem >= 6'd10) begin
            rem  <= rem - 6'd10;
            tens <= tens + 4'd1;
        end
    end

    assign done  = (rem < 6'd10);
    assign units = rem[3:0];

endmodule

// File: rtl/clk_disp_scan.sv
// Six-digit multiplexed 7-segment driver for the hh:mm:ss clock. The time is
// snapshotted once per scan frame, converted to BCD by three subtract-by-ten
// engines, and the lit digit plus blinking colon are driven from registers.
module clk_disp_scan
    import clk_disp_pkg::*;
#(
    parameter int REFRESH_DIV    = 50000,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [5:0]            hh,
    input  logic [5:0]            mm,
    input  logic [5:0]            ss,
    output logic [NUM_DIGITS-1:0] an,
    output logic [6:0]            seg,
    output logic                  dp
);

    localparam int               RC_W    = $clog2(REFRESH_DIV);
    localparam logic [RC_W-1:0]  RC_LAST = RC_W'(REFRESH_DIV - 1);

    logic [RC_W-1:0]            rc;
    logic [2:0]                 di;
    logic                       rc_done;
    logic                       wrap;
    logic                       first_cycle;
    conv_state_t                state;
    conv_state_t                state_next;
    logic                       start;
    logic                       load;
    logic                       done_hh, done_mm, done_ss;
    logic [3:0]                 tens_hh, tens_mm, tens_ss;
    logic [3:0]                 units_hh, units_mm, units_ss;
    logic [NUM_DIGITS-1:0][3:0] disp;
    logic                       ss_lsb;
    logic                       valid;
    logic [3:0]                 cur_digit;
    logic [NUM_DIGITS-1:0]      lit_an;
    logic [6:0]                 lit_seg;
    logic                       lit_dp;

    assign rc_done = (rc == RC_LAST);
    assign wrap    = rc_done && (di == 3'd5);

    // Refresh counter and digit index: each digit stays lit for REFRESH_DIV cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            rc <= '0;
            di <= '0;
        end else if (rc_done) begin
            rc <= '0;
            di <= (di == 3'd5) ? 3'd0 : di + 3'd1;
        end else begin
            rc <= rc + 1'b1;
        end
    end

    // Flags the first cycle out of reset so a snapshot is taken straight away.
    always_ff @(posedge clk) begin
        if (rst) begin
            first_cycle <= 1'b1;
        end else begin
            first_cycle <= 1'b0;
        end
    end

    // Conversion FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Snapshot on trigger while idle; load the display once all three fields are done.
    always_comb begin
        state_next = state;
        start      = 1'b0;
        load       = 1'b0;
        case (state)
            IDLE: begin
                if (first_cycle || wrap) begin
                    start      = 1'b1;
                    state_next = CONV;
                end
            end
            CONV: begin
                if (done_hh && done_mm && done_ss) begin
                    load       = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    clk_bcd_conv u_conv_hh (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .value (hh),
        .tens  (tens_hh),
        .units (units_hh),
        .done  (done_hh)
    );

    clk_bcd_conv u_conv_mm (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .value (mm),
        .tens  (tens_mm),
        .units (units_mm),
        .done  (done_mm)
    );

    clk_bcd_conv u_conv_ss (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .value (ss),
        .tens  (tens_ss),
        .units (units_ss),
        .done  (done_ss)
    );

    // Display registers hold the last finished conversion; units keep the parity of ss.
    always_ff @(posedge clk) begin
        if (rst) begin
            disp   <= '0;
            ss_lsb <= 1'b0;
            valid  <= 1'b0;
        end else if (load) begin
            disp[0] <= tens_hh;
            disp[1] <= units_hh;
            disp[2] <= tens_mm;
            disp[3] <= units_mm;
            disp[4] <= tens_ss;
            disp[5] <= units_ss;
            ss_lsb  <= units_ss[0];
            valid   <= 1'b1;
        end
    end

    // Active-high view of the currently lit digit, blanked until the first load.
    always_comb begin
        cur_digit = disp[di];
        lit_an    = '0;
        lit_seg   = '0;
        lit_dp    = 1'b0;
        if (valid) begin
            lit_an  = digit_anode(di);
            lit_seg = seg_encode(cur_digit);
            lit_dp  = ((di == 3'd1) || (di == 3'd3)) && !ss_lsb;
        end
    end

    // Registered pins with polarity applied only at the boundary.
    always_ff @(posedge clk) begin
        if (rst) begin
            an  <= {NUM_DIGITS{AN_ACTIVE_LOW}};
            seg <= {7{SEG_ACTIVE_LOW}};
            dp  <= SEG_ACTIVE_LOW;
        end else begin
            an  <= lit_an ^ {NUM_DIGITS{AN_ACTIVE_LOW}};
            seg <= lit_seg ^ {7{SEG_ACTIVE_LOW}};
            dp  <= lit_dp ^ SEG_ACTIVE_LOW;
        end
    end

endmodule

// File: tb/tb_clk_disp_scan.sv
// Directed bench for clk_disp_scan with REFRESH_DIV=8 and active-low pins.
// Edge E0 is the first rising edge with rst low; the bench counts edges from it.
module tb_clk_disp_scan;

    logic       clk;
    logic       rst;
    logic [5:0] hh, mm, ss;
    logic [5:0] an;
    logic [6:0] seg;
    logic       dp;
    logic [13:0] obs;

    int checks = 0;
    int errors = 0;
    int eidx   = 0;

    localparam logic [13:0] INACTIVE = 14'h3FFF;

    clk_disp_scan #(
        .REFRESH_DIV    (8),
        .SEG_ACTIVE_LOW (1'b1),
        .AN_ACTIVE_LOW  (1'b1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .hh  (hh),
        .mm  (mm),
        .ss  (ss),
        .an  (an),
        .seg (seg),
        .dp  (dp)
    );

    assign obs = {an, seg, dp};

    // Free-running 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Active-low pin image of an active-high anode/segment/dp triple.
    function automatic logic [13:0] pins(input logic [5:0] a, input logic [6:0] s, input logic d);
        return {~a, ~s, ~d};
    endfunction

    task automatic checkOutput(input string tag, input logic [13:0] got, input logic [13:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got {an,seg,dp}=%h expected %h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic [5:0] h, input logic [5:0] m, input logic [5:0] s);
        hh  = h;
        mm  = m;
        ss  = s;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic releaseReset();
        rst = 1'b0;
        @(posedge clk);
        eidx = 0;
        #1;
    endtask

    task automatic stepTo(input int k);
        repeat (k - eidx) @(posedge clk);
        eidx = k;
        #1;
    endtask

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    logic [6:0] segs_2359 [6];

    initial begin
        segs_2359 = '{7'h5B, 7'h4F, 7'h6D, 7'h6F, 7'h6D, 7'h6F};
        rst = 1'b1;
        hh = '0; mm = '0; ss = '0;

        // 00:00:00 out of reset
        applyStimulus(6'd0, 6'd0, 6'd0);
        checkOutput("reset_inactive", obs, INACTIVE);
        releaseReset();
        checkOutput("e0_inactive", obs, INACTIVE);
        stepTo(1);
        checkOutput("e1_inactive", obs, INACTIVE);
        stepTo(2);
        checkOutput("zero_digit0", obs, pins(6'b100000, 7'h3F, 1'b0));

        // 23:59:59 held: first load at E6, visible at E7, then a full second frame
        applyStimulus(6'd23, 6'd59, 6'd59);
        releaseReset();
        stepTo(6);
        checkOutput("2359_e6_inactive", obs, INACTIVE);
        stepTo(7);
        checkOutput("2359_e7_digit0", obs, pins(6'b100000, 7'h5B, 1'b0));
        stepTo(48);
        for (int d = 0; d < 6; d++) begin
            for (int c = 0; c < 8; c++) begin
                checkOutput($sformatf("2359_frame_d%0d_c%0d", d, c), obs,
                            pins(6'b100000 >> d, segs_2359[d], 1'b0));
                stepTo(eidx + 1);
            end
        end

        // 23:59:58 with ss moving to 59 mid-frame
        applyStimulus(6'd23, 6'd59, 6'd58);
        releaseReset();
        stepTo(8);
        checkOutput("ss58_d1_colon_on", obs, pins(6'b010000, 7'h4F, 1'b1));
        stepTo(20);
        ss = 6'd59;
        stepTo(40);
        checkOutput("ss58_d5_kept_start", obs, pins(6'b000001, 7'h7F, 1'b0));
        stepTo(47);
        checkOutput("ss58_d5_kept_end", obs, pins(6'b000001, 7'h7F, 1'b0));
        stepTo(56);
        checkOutput("ss59_d1_colon_off", obs, pins(6'b010000, 7'h4F, 1'b0));
        stepTo(88);
        checkOutput("ss59_d5_new", obs, pins(6'b000001, 7'h6F, 1'b0));

        // 12:34:56: colon only on digits 1 and 3
        applyStimulus(6'd12, 6'd34, 6'd56);
        releaseReset();
        stepTo(7);
        checkOutput("1234_d0", obs, pins(6'b100000, 7'h06, 1'b0));
        stepTo(8);
        checkOutput("1234_d1_dp", obs, pins(6'b010000, 7'h5B, 1'b1));
        stepTo(16);
        checkOutput("1234_d2", obs, pins(6'b001000, 7'h4F, 1'b0));
        stepTo(24);
        checkOutput("1234_d3_dp", obs, pins(6'b000100, 7'h66, 1'b1));
        stepTo(32);
        checkOutput("1234_d4", obs, pins(6'b000010, 7'h6D, 1'b0));
        stepTo(40);
        checkOutput("1234_d5", obs, pins(6'b000001, 7'h7D, 1'b0));
        stepTo(50);
        checkOutput("1234_f2_d0", obs, pins(6'b100000, 7'h06, 1'b0));

        // Reset three cycles into the frame-2 conversion, new inputs 63:63:63
        rst = 1'b1;
        hh = 6'd63; mm = 6'd63; ss = 6'd63;
        stepTo(51);
        checkOutput("midconv_rst_inactive", obs, INACTIVE);
        releaseReset();
        checkOutput("63_e0_inactive", obs, INACTIVE);
        stepTo(7);
        checkOutput("63_e7_inactive", obs, INACTIVE);
        stepTo(8);
        checkOutput("63_e8_d1", obs, pins(6'b010000, 7'h4F, 1'b0));
        stepTo(16);
        checkOutput("63_d2", obs, pins(6'b001000, 7'h7D, 1'b0));
        stepTo(48);
        checkOutput("63_f2_d0", obs, pins(6'b100000, 7'h7D, 1'b0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/clk_disp_scan.md
# clk_disp_scan

Downstream display stage for the hh/mm/ss digital clock counter. Takes the three 6-bit binary time fields, converts them to BCD with a small sequential subtract-by-ten engine, and drives a time-multiplexed 6-digit common-anode 7-segment display with a blinking colon. A new snapshot of the time is taken once per scan frame, so digits never tear mid-frame.

## Interface
- REFRESH_DIV, 50000: clk cycles each digit is lit; legal range ≥ 8.
- SEG_ACTIVE_LOW, 1: 1 = seg/dp pins active-low; 0 = active-high.
- AN_ACTIVE_LOW, 1: 1 = anode enables active-low; 0 = active-high.
- clk  in  1  system clock; all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- hh   in  6  hours, binary, 0..23 nominal.
- mm   in  6  minutes, binary, 0..59 nominal.
- ss   in  6  seconds, binary, 0..59 nominal.
- an   out 6  digit enables; an[5] = leftmost (hours tens) … an[0] = seconds units.
- seg  out 7  segments {g,f,e,d,c,b,a}.
- dp   out 1  decimal point of the active digit (colon).

## Operation
- Refresh counter rc counts 0..REFRESH_DIV-1; at terminal count, digit index di advances 0→1→…→5→0.
- di mapping: 0 hh tens (an[5]), 1 hh units, 2 mm tens, 3 mm units, 4 ss tens, 5 ss units (an[0]).
- Conversion FSM, states IDLE, CONV:
  - Capture trigger: first cycle after rst deasserts, and every di wrap 5→0. In IDLE on trigger: rem_x ← input, tens_x ← 0 for x ∈ {hh,mm,ss}; go CONV.
  - CONV, any rem_x ≥ 10: for each such field rem_x −= 10, tens_x += 1; stay.
  - CONV, all rem_x < 10: load display registers {tens,units}×3 and ss_lsb ← captured ss[0]; set valid; go IDLE.
- Out-of-range inputs are converted literally (60..63 → tens digit 6); no clamping, no error flag.
- Segment code (active-high, gfedcba): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F; digit values >9 impossible.
- dp asserted only when di ∈ {1,3} and ss_lsb = 0 (colon blinks at 0.5 Hz with a 1 Hz seconds counter).
- valid = 0: all anodes inactive, seg and dp inactive.
- Polarity parameters invert only the output pins; internal logic is active-high.

## Timing
- Reset values: rc=0, di=0, FSM IDLE, display regs 0, valid=0, an/seg/dp all inactive level (all-ones when the respective *_ACTIVE_LOW = 1).
- an, seg, dp registered: reflect di/display regs one cycle after they change.
- Conversion latency from capture cycle C: display regs load at C+1+max(tens_x); max C+7 (input 63). 23:59:59 loads at C+6; 00:00:00 at C+1.
- REFRESH_DIV ≥ 8 guarantees conversion finishes before di leaves 0; trigger cannot occur in CONV.
- Display regs change only on load; a load during di=0 updates the lit digit on the next registered output.
- Input changes during CONV ignored (snapshot semantics).
- rst mid-conversion: FSM aborts to IDLE, valid=0, all reset values next cycle; a fresh capture follows the first non-reset cycle.

## Structure
- Package clk_disp_pkg: FSM state enum {IDLE,CONV}, NUM_DIGITS=6, 16-entry segment encode constant/function, di→anode one-hot mapping.
- Sub-module clk_bcd_conv: one 6-bit subtract-by-ten converter (start, value in; tens, units, done out); instantiated three times, FSM waits for all three done.
- Top holds rc, di, FSM, display regs, output registers.

## Test plan
- Reset, REFRESH_DIV=8, inputs 00:00:00 → outputs inactive during reset; valid by 2 cycles after release; di=0 shows seg 3F on an[5].
- Inputs 23:59:59 held → over one frame digits read 2,3,5,9,5,9 (seg 5B,4F,6D,6F,6D,6F) on an[5]..an[0] in order, each for 8 cycles; dp off (ss odd).
- ss changes 58→59 mid-frame → current frame keeps 58 on all digits; new value appears only after next 5→0 wrap + conversion.
- Input 63:63:63 → digits 6,3 each field (7D,4F), load exactly 7 cycles after capture.
- ss even (e.g. 12:34:56) → dp active only on di=1 and di=3; ss odd → dp never active.
- Assert rst 3 cycles into CONV → next cycle all outputs inactive, valid=0; after release, capture, conversion, and scan restart from di=0.
